// File: rtl/telemetry_uart_streamer.sv
// Multi-channel telemetry streamer: buffers N-channel sample frames in a FIFO and
// serialises each one over a UART 8N1 line as sync, seq, payload bytes, checksum.
module telemetry_uart_streamer #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 1_000_000,
    parameter int unsigned NUM_CHANNELS     = 2,
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_CHANNELS*WIDTH-1:0] data_in,
    input  logic                          valid_in,
    output logic                          tx_wire_out,
    output logic                          busy_out,
    output logic                          frame_dropped_out,
    output logic [15:0]                   drop_count_out
);

    localparam int unsigned BAUD_DIV  = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned BYTES     = (WIDTH + 7) / 8;
    localparam int unsigned NPAY      = NUM_CHANNELS * BYTES;
    localparam int unsigned FRAME_LEN = 3 + NPAY;
    localparam int unsigned FW        = NUM_CHANNELS * WIDTH;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned BW        = $clog2(BAUD_DIV);
    localparam int unsigned IW        = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e state_q, state_d;

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          not_full, push_ok, pop;

    logic [FW-1:0] frame_q, frame_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    seq_q, seq_d;
    logic          dropped_q, dropped_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [7:0]         pay_bytes [NPAY];
    logic [BYTES*8-1:0] ext;
    logic [7:0]         cur_byte;
    logic [2:0]         bit_sel;
    logic               bit_end, byte_end, frame_end;

    // Full is judged on the occupancy at the start of the cycle, so a pop never rescues a push.
    assign not_full = (count_q != (AW + 1)'(FIFO_DEPTH));
    assign push_ok  = valid_in && not_full;

    assign bit_end   = (baud_q == BW'(BAUD_DIV - 1));
    assign byte_end  = bit_end && (bit_q == 4'd9);
    assign frame_end = byte_end && (idx_q == IW'(FRAME_LEN - 1));

    // Split the latched frame into zero-extended, MSB-first payload bytes and pick the current one.
    always_comb begin
        ext = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            ext = '0;
            ext[WIDTH-1:0] = frame_q[k*WIDTH +: WIDTH];
            for (int b = 0; b < BYTES; b++) begin
                pay_bytes[k*BYTES + b] = ext[(BYTES-1-b)*8 +: 8];
            end
        end
        cur_byte = csum_q;
        if (idx_q == IW'(0)) begin
            cur_byte = 8'hA5;
        end else if (idx_q == IW'(1)) begin
            cur_byte = seq_q;
        end else begin
            for (int p = 0; p < NPAY; p++) begin
                if (idx_q == IW'(p + 2)) cur_byte = pay_bytes[p];
            end
        end
        bit_sel = 3'(bit_q - 4'd1);
    end

    // FIFO pointer, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dropped_d  = valid_in && !not_full;
        drop_cnt_d = drop_cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop) count_d = count_q + (AW + 1)'(1);
        if (!push_ok && pop) count_d = count_q - (AW + 1)'(1);
        if (dropped_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Baud/bit/byte sequencing, running checksum and sequence number.
    always_comb begin
        frame_d = frame_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        seq_d   = seq_q;
        if (state_q == StLoad) begin
            frame_d = mem_q[rd_ptr_q];
            baud_d  = '0;
            bit_d   = '0;
            idx_d   = '0;
            csum_d  = '0;
        end else if (state_q == StSend) begin
            if (!bit_end) begin
                baud_d = baud_q + BW'(1);
            end else begin
                baud_d = '0;
                if (bit_q != 4'd9) begin
                    bit_d = bit_q + 4'd1;
                end else begin
                    bit_d = '0;
                    idx_d = frame_end ? '0 : idx_q + IW'(1);
                    // Sync byte and the checksum byte itself are excluded from the sum.
                    if ((idx_q != IW'(0)) && (idx_q != IW'(FRAME_LEN - 1))) begin
                        csum_d = csum_q + cur_byte;
                    end
                    if (frame_end) seq_d = seq_q + 8'd1;
                end
            end
        end
    end

    // Frame storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_in;
    end

    // Datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            frame_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            dropped_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            frame_q    <= frame_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            dropped_q  <= dropped_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state; an accepted push counts as non-empty so LOAD follows straight away.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if ((count_q != '0) || push_ok) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  if (frame_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; the line is driven from state so reset releases it high at once.
    always_comb begin
        tx_wire_out = 1'b1;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: tx_wire_out = 1'b1;
            StLoad: pop = 1'b1;
            StSend: begin
                if (bit_q == 4'd0)      tx_wire_out = 1'b0;
                else if (bit_q == 4'd9) tx_wire_out = 1'b1;
                else                    tx_wire_out = cur_byte[bit_sel];
            end
            default: tx_wire_out = 1'b1;
        endcase
    end

    assign busy_out          = (count_q != '0) || (state_q != StIdle);
    assign frame_dropped_out = dropped_q;
    assign drop_count_out    = drop_cnt_q;

endmodule

// File: tb/tb_telemetry_uart_streamer.sv
// Scoreboard bench: stimulus pushes expected wire bytes, a UART monitor decodes and compares.
module tb_telemetry_uart_streamer;

    localparam int unsigned CLK_HZ = 3_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int unsigned BD     = CLK_HZ / BAUD;
    localparam int unsigned NC     = 2;
    localparam int unsigned W      = 12;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NBYTES = (W + 7) / 8;
    localparam int unsigned L      = 3 + NC * NBYTES;
    localparam int unsigned FRAME_CYC = L * 10 * BD;

    logic            clk_in;
    logic            rst_in;
    logic [NC*W-1:0] data_in;
    logic            valid_in;
    logic            tx_wire_out;
    logic            busy_out;
    logic            frame_dropped_out;
    logic [15:0]     drop_count_out;

    telemetry_uart_streamer #(
        .INPUT_CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE       (BAUD),
        .NUM_CHANNELS    (NC),
        .WIDTH           (W),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .tx_wire_out      (tx_wire_out),
        .busy_out         (busy_out),
        .frame_dropped_out(frame_dropped_out),
        .drop_count_out   (drop_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    int         model_seq = 0;
    int         last_gap  = 0;
    int         drop_pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the byte image of a frame, built straight from the framing rules.
    task automatic model_push(input logic [NC*W-1:0] d);
        int sum;
        int w;
        int bv;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(model_seq));
        sum = model_seq;
        for (int k = 0; k < NC; k++) begin
            w = int'(d[k*W +: W]);
            for (int b = NBYTES - 1; b >= 0; b--) begin
                bv = (w >> (8 * b)) & 255;
                exp_q.push_back(8'(bv));
                sum += bv;
            end
        end
        exp_q.push_back(8'(sum & 255));
        model_seq = (model_seq + 1) % 256;
    endtask

    function automatic logic [NC*W-1:0] rand_frame();
        logic [NC*W-1:0] d;
        for (int k = 0; k < NC; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic send(input logic [NC*W-1:0] d);
        @(negedge clk_in);
        data_in  = d;
        valid_in = 1'b1;
        model_push(d);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    // Only push when fewer than DEPTH-1 frames can still be waiting, so nothing is dropped.
    task automatic send_throttled(input logic [NC*W-1:0] d);
        int budget;
        budget = 0;
        while (exp_q.size() >= L * (DEPTH - 1) && budget < 4 * FRAME_CYC) begin
            @(negedge clk_in);
            budget++;
        end
        if (budget >= 4 * FRAME_CYC) check("throttle_timeout", 1, 0);
        send(d);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy_out) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("drain_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    always @(negedge clk_in) if (frame_dropped_out) drop_pulses++;

    // UART monitor: decodes each byte, verifies bit hold time, stop bit and framing gaps.
    initial begin : monitor
        int         bidx;
        int         gap;
        int         glitches;
        bit         abort;
        logic [9:0] bits;
        logic       v0;
        bidx = 0;
        v0   = 1'b0;
        forever begin
            gap = 0;
            @(negedge clk_in);
            while (tx_wire_out !== 1'b0 || rst_in) begin
                gap++;
                @(negedge clk_in);
            end
            if (bidx == 0) last_gap = gap;
            else check("intra_frame_gap", gap, 0);
            glitches = 0;
            abort    = 1'b0;
            bits     = '0;
            for (int b = 0; b < 10 && !abort; b++) begin
                for (int c = 0; c < BD && !abort; c++) begin
                    if (b != 0 || c != 0) @(negedge clk_in);
                    if (rst_in) abort = 1'b1;
                    else if (c == 0) v0 = tx_wire_out;
                    else if (tx_wire_out !== v0) glitches++;
                end
                bits[b] = v0;
            end
            if (abort) begin
                bidx = 0;
            end else begin
                check("bit_hold", glitches, 0);
                check("stop_bit", int'(bits[9]), 1);
                if (exp_q.size() == 0) check("unexpected_byte", int'(bits[8:1]), -1);
                else check("byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                bidx = (bidx + 1) % L;
            end
        end
    end

    initial begin : stim
        int lows;
        int n;
        int d0;
        rst_in   = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) @(negedge clk_in);
        check("rst_tx", int'(tx_wire_out), 1);
        check("rst_busy", int'(busy_out), 0);
        check("rst_drop", int'(frame_dropped_out), 0);
        check("rst_dcount", int'(drop_count_out), 0);
        @(posedge clk_in);
        #2 rst_in = 1'b0;

        // First-frame latency: busy one cycle after the strobe, start bit two cycles after.
        @(negedge clk_in);
        data_in  = {12'hABC, 12'h001};
        valid_in = 1'b1;
        model_push(data_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        check("lat_busy_t1", int'(busy_out), 1);
        check("lat_tx_t1", int'(tx_wire_out), 1);
        @(negedge clk_in);
        check("lat_tx_t2", int'(tx_wire_out), 0);
        wait_idle(2 * FRAME_CYC);

        // Back-to-back frames: 2 idle-high cycles between frames, busy never drops.
        @(negedge clk_in);
        data_in  = rand_frame();
        valid_in = 1'b1;
        model_push(data_in);
        @(negedge clk_in);
        data_in = rand_frame();
        model_push(data_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        lows = 0;
        n    = 0;
        while (exp_q.size() != 0 && n < 3 * FRAME_CYC) begin
            if (!busy_out) lows++;
            @(negedge clk_in);
            n++;
        end
        check("b2b_busy_low", lows, 0);
        check("b2b_gap", last_gap, 2);
        wait_idle(2 * FRAME_CYC);

        // Randomised traffic with random spacing.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, FRAME_CYC / 2)) @(negedge clk_in);
            send_throttled(rand_frame());
        end
        wait_idle(30 * FRAME_CYC);

        // Overflow: 20 strobes on consecutive cycles from idle; one frame leaves for LOAD
        // immediately, so DEPTH+1 are kept and the rest are dropped.
        d0 = drop_pulses;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            data_in  = rand_frame();
            valid_in = 1'b1;
            if (i < DEPTH + 1) model_push(data_in);
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        wait_idle(20 * FRAME_CYC);
        check("ovf_drop_pulses", drop_pulses - d0, 3);
        check("ovf_drop_count", int'(drop_count_out), 3);

        // Reset in the third byte of a frame.
        send(rand_frame());
        n = 0;
        while (exp_q.size() > L - 2 && n < 2 * FRAME_CYC) begin
            @(negedge clk_in);
            n++;
        end
        check("mid_wait_timeout", (n >= 2 * FRAME_CYC) ? 1 : 0, 0);
        repeat (4 * BD) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        exp_q.delete();
        model_seq = 0;
        #1;
        check("mid_rst_tx", int'(tx_wire_out), 1);
        check("mid_rst_busy", int'(busy_out), 0);
        check("mid_rst_drop", int'(frame_dropped_out), 0);
        check("mid_rst_dcount", int'(drop_count_out), 0);
        @(posedge clk_in);
        #2 rst_in = 1'b0;

        // Fresh frame after reset carries seq 0, then 256 more so the sequence wraps FF->00.
        send(rand_frame());
        for (int i = 0; i < 256; i++) send_throttled(rand_frame());
        wait_idle(20 * FRAME_CYC);
        check("end_dcount", int'(drop_count_out), 0);
        check("end_model_seq", model_seq, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_uart_streamer.md
# telemetry_uart_streamer

Parametrised multi-channel telemetry streamer for the autotune debug path: captures N-channel sample words (e.g. processed audio, taumin, pitch-shifted output) into a frame FIFO and serialises each frame over a UART 8N1 line with sync byte, sequence number and checksum. It is the multi-channel, framed, loss-reporting generation of the single-word turbo UART transmitter feeding `uart_txd`.

## Interface

Parameters:
- `INPUT_CLOCK_FREQ`, 100_000_000: system clock in Hz.
- `BAUD_RATE`, 1_000_000: line rate; `BAUD_DIV = INPUT_CLOCK_FREQ / BAUD_RATE` (integer, must be ≥ 2).
- `NUM_CHANNELS`, 2: words per frame (1–8).
- `WIDTH`, 16: bits per channel word (1–32); `BYTES = ceil(WIDTH/8)`.
- `FIFO_DEPTH`, 16: frame capacity of the FIFO (power of two, ≥ 2).

Ports:
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset; one clock; reset is asynchronous and active-high.
- `data_in`  input  NUM_CHANNELS*WIDTH  channel k = `data_in[k*WIDTH +: WIDTH]`.
- `valid_in`  input  1  single-cycle strobe: capture `data_in` as one frame.
- `tx_wire_out`  output  1  UART line, idle high.
- `busy_out`  output  1  high while the FIFO is non-empty or a frame is being sent.
- `frame_dropped_out`  output  1  one-cycle pulse when a `valid_in` frame is discarded.
- `drop_count_out`  output  16  saturating count of discarded frames.

## Operation

- Capture: on `valid_in` with FIFO not full (full evaluated from the occupancy at the start of the cycle), push `data_in`. If full, discard the frame, pulse `frame_dropped_out` next cycle, increment `drop_count_out` (saturates at 0xFFFF). A push while full is dropped even if a pop occurs in the same cycle.
- Frame on the wire, in order: `0xA5`; `seq`; for k = 0..NUM_CHANNELS-1, the channel word zero-extended to BYTES*8 bits, MSB byte first; checksum = sum mod 256 of `seq` and all payload bytes (sync excluded). Frame length `L = 3 + NUM_CHANNELS*BYTES` bytes.
- `seq`: 8-bit, starts at 0, increments after each fully transmitted frame, wraps 255→0. Dropped frames do not consume a sequence number.
- Byte format: 8N1: start bit (0), 8 data bits LSB first, stop bit (1). Each bit held exactly BAUD_DIV cycles.
- FSM: IDLE → (FIFO non-empty) LOAD: pop the frame, latch it, build the byte sequence → SEND: shift bytes back-to-back with no gap between a stop bit and the next start bit → after the last stop bit, IDLE.
- Byte sequencing uses a byte index counter 0..L-1, a bit counter 0..9 and a baud counter 0..BAUD_DIV-1. The checksum accumulates as bytes are emitted.

## Timing

- Reset (asynchronous): `tx_wire_out`=1, `busy_out`=0, `frame_dropped_out`=0, `drop_count_out`=0, `seq`=0, FIFO empty, FSM IDLE. Reset mid-frame abandons the frame and immediately releases the line high. No partial frame is resumed.
- Latency: `valid_in` at cycle t into an empty FIFO with FSM IDLE → IDLE sees non-empty at t+1 → LOAD at t+1 → start bit begins at t+2 (`tx_wire_out` low from t+2).
- Frame duration: `L*10*BAUD_DIV` cycles. Queued frames start with exactly 2 idle-high cycles after the previous stop bit (IDLE, LOAD).
- `busy_out` rises the cycle after an accepted push and falls the cycle after the last stop bit ends with the FIFO empty.
- Simultaneous push and pop while not full: both happen; occupancy is unchanged.

## Test plan

- Single frame, defaults, BAUD_DIV=100: `data_in`=32'hABCD_1234 → bytes A5,00,12,34,AB,CD,BE. Each start bit low exactly 100 cycles. The first start bit begins 2 cycles after `valid_in`.
- WIDTH=12, NUM_CHANNELS=1: word 12'hABC → bytes A5,00,0A,BC,C6. A second frame of 12'h001 carries seq 01 and checksum 02.
- Overflow, FIFO_DEPTH=16: 20 `valid_in` on consecutive cycles with the FSM idle → 17 frames sent with seq 00..10 (hex). 3 `frame_dropped_out` pulses. `drop_count_out`=3.
- Back-to-back frames: two queued frames → exactly 2 high cycles between the last stop bit of frame 0 and the start bit of frame 1. `busy_out` is continuously high across both.
- Seq wrap: send 257 frames → the 256th frame carries seq FF and the 257th carries 00.
- Reset mid-frame: assert `rst_in` during the 3rd byte → `tx_wire_out`=1 immediately and all outputs take their reset values. A new frame after release starts with A5,00.
